// File: rtl/led_pio_pkg.sv
// Shared constants for the Avalon LED PIO: register addresses, PWM width, STATUS bit positions.
package led_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_MASK   = 3'd1;
    localparam logic [2:0] ADDR_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_DUTY   = 3'd3;
    localparam logic [2:0] ADDR_SET    = 3'd4;
    localparam logic [2:0] ADDR_CLR    = 3'd5;
    localparam logic [2:0] ADDR_TOGGLE = 3'd6;
    localparam logic [2:0] ADDR_STATUS = 3'd7;

    localparam int PWM_W      = 8;
    localparam int STAT_PHASE = 0;
    localparam int STAT_PWM   = 1;

    // Full-scale duty forces the output permanently on; otherwise compare against the ramp.
    function automatic logic pwm_gate(input logic [PWM_W-1:0] cnt, input logic [PWM_W-1:0] duty);
        return (duty == {PWM_W{1'b1}}) || (cnt < duty);
    endfunction

endpackage

// File: rtl/led_blink_timer.sv
// Free-running tick prescaler plus half-period blink counter producing the blink phase.
module led_blink_timer #(
    parameter int PRESCALE = 50000,
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick,
    output logic                phase
);

    localparam int              PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0]    r_pre;
    logic [PERIOD_W-1:0] r_cnt;
    logic                r_phase;

    assign tick  = (r_pre == PRE_MAX);
    assign phase = r_phase;

    // clear wins over a coincident tick so a period rewrite always restarts cleanly
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_pre   <= '0;
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else begin
            r_pre <= tick ? '0 : r_pre + 1'b1;
            if (period == '0) begin
                r_cnt   <= '0;
                r_phase <= 1'b0;
            end else if (tick) begin
                if (r_cnt == period - PERIOD_W'(1)) begin
                    r_cnt   <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_cnt <= r_cnt + PERIOD_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/avalon_led_pio.sv
// Avalon-MM LED PIO: DATA with SET/CLR/TOGGLE, per-bit blink, registered LED drive.
// Optional global PWM dimming is built when LED_PIO_PWM_EN is defined.
module avalon_led_pio
    import led_pio_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int PRESCALE = 50000,
    parameter int PERIOD_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic             read_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic                w_wr;
    logic                w_rd;
    logic                w_clear;
    logic                w_tick;
    logic                w_phase;
    logic                w_pwm_on;
    logic [31:0]         w_rdata;
    logic                w_unused;

    logic [WIDTH-1:0]    r_data;
    logic [WIDTH-1:0]    r_mask;
    logic [PERIOD_W-1:0] r_period;
    logic [31:0]         r_readdata;
    logic [WIDTH-1:0]    r_out;

    assign w_wr     = chipselect & ~write_n;
    assign w_rd     = chipselect & ~read_n;
    assign w_clear  = w_wr && (address == ADDR_PERIOD);
    assign w_unused = ^{writedata, w_tick};

    led_blink_timer #(
        .PRESCALE (PRESCALE),
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_clear),
        .period (r_period),
        .tick   (w_tick),
        .phase  (w_phase)
    );

`ifdef LED_PIO_PWM_EN
    logic [PWM_W-1:0] r_duty;
    logic [PWM_W-1:0] r_pwm_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_duty    <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (w_wr && (address == ADDR_DUTY))
                r_duty <= writedata[PWM_W-1:0];
        end
    end

    assign w_pwm_on = pwm_gate(r_pwm_cnt, r_duty);
`else
    assign w_pwm_on = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data   <= '0;
            r_mask   <= '0;
            r_period <= '0;
        end else if (w_wr) begin
            case (address)
                ADDR_DATA:   r_data   <= writedata[WIDTH-1:0];
                ADDR_MASK:   r_mask   <= writedata[WIDTH-1:0];
                ADDR_PERIOD: r_period <= writedata[PERIOD_W-1:0];
                ADDR_SET:    r_data   <= r_data | writedata[WIDTH-1:0];
                ADDR_CLR:    r_data   <= r_data & ~writedata[WIDTH-1:0];
                ADDR_TOGGLE: r_data   <= r_data ^ writedata[WIDTH-1:0];
                default:     ;
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_DATA, ADDR_SET, ADDR_CLR, ADDR_TOGGLE: w_rdata[WIDTH-1:0] = r_data;
            ADDR_MASK:   w_rdata[WIDTH-1:0]    = r_mask;
            ADDR_PERIOD: w_rdata[PERIOD_W-1:0] = r_period;
`ifdef LED_PIO_PWM_EN
            ADDR_DUTY:   w_rdata[PWM_W-1:0]    = r_duty;
`endif
            ADDR_STATUS: begin
                w_rdata[STAT_PHASE] = w_phase;
                w_rdata[STAT_PWM]   = w_pwm_on;
            end
            default:     w_rdata = '0;
        endcase
    end

    // Read mux sees pre-write register values, so a same-cycle read/write returns the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
            r_out      <= '0;
        end else begin
            r_readdata <= w_rd ? w_rdata : 32'd0;
            r_out      <= r_data & ~(r_mask & {WIDTH{w_phase}}) & {WIDTH{w_pwm_on}};
        end
    end

    assign readdata = r_readdata;
    assign out_port = r_out;

endmodule

// File: tb/tb_avalon_led_pio.sv
// Self-checking bench for avalon_led_pio: time-based reference model plus directed literal checks.
module tb_avalon_led_pio;

    localparam int W  = 10;
    localparam int P  = 4;
    localparam int PW = 16;
`ifdef LED_PIO_PWM_EN
    localparam logic [31:0] STAT_IDLE = 32'd0;
`else
    localparam logic [31:0] STAT_IDLE = 32'd2;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [W-1:0] out_port;

    always #5 clk = ~clk;

    avalon_led_pio #(.WIDTH(W), .PRESCALE(P), .PERIOD_W(PW)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: blink phase derived from cycles elapsed since the last reset/period write.
    logic [W-1:0]  m_data, m_mask, m_out;
    logic [PW-1:0] m_period;
    logic [7:0]    m_duty, m_pcnt;
    int unsigned   m_t;
    logic [31:0]   m_rd;
    bit            m_ok = 1'b0;

    function automatic logic f_phase(input int unsigned t, input logic [PW-1:0] per);
        if (per == '0) return 1'b0;
        return (((t / P) / per) % 2) == 1;
    endfunction

    function automatic logic f_pwm(input logic [7:0] cnt, input logic [7:0] duty);
`ifdef LED_PIO_PWM_EN
        return (duty == 8'd255) || (cnt < duty);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [31:0] f_read(input logic [2:0] a);
        case (a)
            3'd0, 3'd4, 3'd5, 3'd6: return {22'd0, m_data};
            3'd1: return {22'd0, m_mask};
            3'd2: return {16'd0, m_period};
`ifdef LED_PIO_PWM_EN
            3'd3: return {24'd0, m_duty};
`endif
            3'd7: return {30'd0, f_pwm(m_pcnt, m_duty), f_phase(m_t, m_period)};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_data <= '0; m_mask <= '0; m_period <= '0; m_duty <= '0;
            m_pcnt <= '0; m_t <= 0; m_rd <= '0; m_out <= '0; m_ok <= 1'b1;
        end else begin
            m_pcnt <= m_pcnt + 8'd1;
            m_t    <= m_t + 1;
            m_rd   <= (chipselect && !read_n) ? f_read(address) : 32'd0;
            m_out  <= m_data & ~(m_mask & {W{f_phase(m_t, m_period)}}) & {W{f_pwm(m_pcnt, m_duty)}};
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_data <= writedata[W-1:0];
                    3'd1: m_mask <= writedata[W-1:0];
                    3'd2: begin m_period <= writedata[PW-1:0]; m_t <= 0; end
`ifdef LED_PIO_PWM_EN
                    3'd3: m_duty <= writedata[7:0];
`endif
                    3'd4: m_data <= m_data | writedata[W-1:0];
                    3'd5: m_data <= m_data & ~writedata[W-1:0];
                    3'd6: m_data <= m_data ^ writedata[W-1:0];
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("model readdata", readdata, m_rd);
            check("model out_port", {22'd0, out_port}, {22'd0, m_out});
        end
    end

    // Tasks start at a falling edge and return at the next one.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        chipselect = 1'b1; read_n = 1'b0; address = a;
        @(negedge clk);
        v = readdata;
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read_all_zero(input string tag);
        logic [31:0] v;
        rd(3'd0, v); check({tag, " DATA"}, v, 32'd0);
        rd(3'd1, v); check({tag, " MASK"}, v, 32'd0);
        rd(3'd2, v); check({tag, " PERIOD"}, v, 32'd0);
        rd(3'd7, v); check({tag, " STATUS"}, v, STAT_IDLE);
    endtask

    initial begin
        logic [31:0] v;
        int cnt;
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
        address = 3'd0; writedata = 32'd0;
        idle(2);
        reset = 1'b0;
        read_all_zero("reset");
        check("reset out_port", {22'd0, out_port}, 32'd0);
`ifdef LED_PIO_PWM_EN
        wr(3'd3, 32'hFF);
`endif
        // read-modify-write aliases
        wr(3'd0, 32'h0F0);
        wr(3'd4, 32'h003);
        wr(3'd5, 32'h010);
        wr(3'd6, 32'h201);
        rd(3'd0, v);
        check("rmw DATA", v, 32'h2E2);
        check("rmw out_port", {22'd0, out_port}, 32'h2E2);
        // blink: flips every PRESCALE*PERIOD = 8 cycles from the period write
        wr(3'd0, 32'h3FF);
        wr(3'd1, 32'h00F);
        wr(3'd2, 32'd2);
        idle(1); check("blink k1", {22'd0, out_port}, 32'h3FF);
        idle(7); check("blink k8", {22'd0, out_port}, 32'h3FF);
        idle(1); check("blink k9", {22'd0, out_port}, 32'h3F0);
        rd(3'd7, v); check("blink STATUS", v, 32'd3);
        idle(7); check("blink k17", {22'd0, out_port}, 32'h3FF);
        // SET lands exactly on the flip edge at k=24
        wr(3'd5, 32'h300);
        idle(5);
        wr(3'd4, 32'h200);
        check("pre-flip out_port", {22'd0, out_port}, 32'h0FF);
        idle(1); check("flip+SET out_port", {22'd0, out_port}, 32'h2F0);
        // PERIOD write on the tick edge at k=28 restarts phase and count
        idle(2);
        wr(3'd2, 32'd2);
        rd(3'd7, v); check("period-on-tick STATUS", v, 32'd2);
        idle(7); check("restart k8", {22'd0, out_port}, 32'h2FF);
        idle(1); check("restart k9", {22'd0, out_port}, 32'h2F0);
        // period 0 holds phase at 0
        wr(3'd2, 32'd0);
        idle(20);
        rd(3'd7, v); check("period0 phase", {31'd0, v[0]}, 32'd0);
`ifdef LED_PIO_PWM_EN
        wr(3'd0, 32'h3FF);
        wr(3'd3, 32'd64);
        idle(1);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin @(negedge clk); if (out_port != '0) cnt++; end
        check("pwm duty64 on-count", cnt, 32'd64);
        wr(3'd3, 32'd0);
        idle(1);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin @(negedge clk); if (out_port != '0) cnt++; end
        check("pwm duty0 on-count", cnt, 32'd0);
        wr(3'd3, 32'd255);
        idle(1);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin @(negedge clk); if (out_port == 10'h3FF) cnt++; end
        check("pwm duty255 full-count", cnt, 32'd256);
        wr(3'd3, 32'd128);
`endif
        // mid-operation reset
        wr(3'd1, 32'h3FF);
        wr(3'd2, 32'd1);
        idle(11);
        reset = 1'b1;
        idle(1);
        check("midreset out_port", {22'd0, out_port}, 32'd0);
        reset = 1'b0;
        read_all_zero("midreset");
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
